// File: rtl/stream_arbiter.sv
// Packet-level N:1 valid/ready arbiter (round-robin or fixed priority) feeding one registered output.
// Latency: request seen in IDLE -> grant next cycle -> first beat on m_* one cycle later; one IDLE cycle between packets.
// Backpressure: only the granted port sees ready, and only while the output register can load (!m_valid_o | m_ready_i).
//
// Ports:
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   s_data_i/s_valid_i/s_last_i/s_ready_o   N input streams, port i data at [(i+1)*DATAW-1 : i*DATAW]
//   m_data_o/m_valid_o/m_last_o/m_ready_i   merged output stream (registered)
//   m_sel_o               source port of the beat currently on m_data_o
module stream_arbiter #(
  parameter int N           = 4,
  parameter int DATAW       = 8,
  parameter int ROUND_ROBIN = 1,
  localparam int SELW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N*DATAW-1:0]   s_data_i,
  input  logic [N-1:0]         s_valid_i,
  input  logic [N-1:0]         s_last_i,
  output logic [N-1:0]         s_ready_o,
  output logic [DATAW-1:0]     m_data_o,
  output logic                 m_valid_o,
  output logic                 m_last_o,
  input  logic                 m_ready_i,
  output logic [SELW-1:0]      m_sel_o
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Reset pointer at the top port so the first round-robin search begins at port 0.
  localparam logic [SELW-1:0] RR_INIT = SELW'(N - 1);

  state_t            r_state;
  logic [SELW-1:0]   r_grant;
  logic [SELW-1:0]   r_rr_ptr;
  logic [DATAW-1:0]  r_m_data;
  logic              r_m_valid;
  logic              r_m_last;
  logic [SELW-1:0]   r_m_sel;

  logic [N-1:0]      w_hi;
  logic [SELW-1:0]   w_pick;
  logic              w_can_load;
  logic              w_busy;
  logic              w_gnt_valid;
  logic              w_gnt_last;
  logic              w_acc;
  logic [DATAW-1:0]  w_beat;
  logic [N-1:0]      w_ready;

  // Requests strictly above the last-served port; empty in fixed-priority mode,
  // which makes the pick fall through to plain lowest-index priority.
  always_comb begin
    w_hi = '0;
    for (int i = 0; i < N; i++) begin
      if (ROUND_ROBIN != 0 && i > int'(r_rr_ptr)) begin
        w_hi[i] = s_valid_i[i];
      end
    end
  end

  // Lowest set index: scan downwards so the last hit is the lowest index.
  always_comb begin
    w_pick = '0;
    if (|w_hi) begin
      for (int i = N - 1; i >= 0; i--) begin
        if (w_hi[i]) w_pick = SELW'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (s_valid_i[i]) w_pick = SELW'(i);
      end
    end
  end

  assign w_can_load  = !r_m_valid || m_ready_i;
  assign w_busy      = (r_state == S_BUSY);
  assign w_gnt_valid = s_valid_i[r_grant];
  assign w_gnt_last  = s_last_i[r_grant];
  assign w_beat      = s_data_i[r_grant*DATAW +: DATAW];
  assign w_acc       = w_busy && w_can_load && w_gnt_valid;

  // Ready is combinational on m_ready_i so a packet streams at one beat per cycle.
  always_comb begin
    w_ready = '0;
    for (int i = 0; i < N; i++) begin
      w_ready[i] = w_busy && w_can_load && (r_grant == SELW'(i));
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_grant   <= '0;
      r_rr_ptr  <= RR_INIT;
      r_m_data  <= '0;
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_sel   <= '0;
    end else begin
      // Output register: load on accept, drain when downstream takes the beat.
      if (w_acc) begin
        r_m_data  <= w_beat;
        r_m_last  <= w_gnt_last;
        r_m_sel   <= r_grant;
        r_m_valid <= 1'b1;
      end else if (w_can_load) begin
        r_m_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (|s_valid_i) begin
            r_grant <= w_pick;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          // Grant is held until the last beat; a stalled granted port simply waits.
          if (w_acc && w_gnt_last) begin
            if (ROUND_ROBIN != 0) r_rr_ptr <= r_grant;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_ready_o = w_ready;
  assign m_data_o  = r_m_data;
  assign m_valid_o = r_m_valid;
  assign m_last_o  = r_m_last;
  assign m_sel_o   = r_m_sel;

endmodule

// File: tb/tb_stream_arbiter.sv
// Self-checking bench for stream_arbiter: round-robin instance under random traffic
// against a transaction-level model, plus a fixed-priority instance with directed traffic.
module tb_stream_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // round-robin DUT
  logic [N*DW-1:0] a_data = '0;
  logic [N-1:0]    a_valid = '0, a_last = '0, a_ready;
  logic [DW-1:0]   a_mdata;
  logic            a_mvalid, a_mlast;
  logic            a_mready = 1'b0;
  logic [SW-1:0]   a_msel;

  // fixed-priority DUT
  logic [N*DW-1:0] b_data = '0;
  logic [N-1:0]    b_valid = '0, b_last = '0, b_ready;
  logic [DW-1:0]   b_mdata;
  logic            b_mvalid, b_mlast;
  logic            b_mready = 1'b0;
  logic [SW-1:0]   b_msel;

  stream_arbiter #(.N(N), .DATAW(DW), .ROUND_ROBIN(1)) u_rr (
    .clk_i(clk), .rst_ni(rst_n),
    .s_data_i(a_data), .s_valid_i(a_valid), .s_last_i(a_last), .s_ready_o(a_ready),
    .m_data_o(a_mdata), .m_valid_o(a_mvalid), .m_last_o(a_mlast), .m_ready_i(a_mready),
    .m_sel_o(a_msel)
  );

  stream_arbiter #(.N(N), .DATAW(DW), .ROUND_ROBIN(0)) u_fp (
    .clk_i(clk), .rst_ni(rst_n),
    .s_data_i(b_data), .s_valid_i(b_valid), .s_last_i(b_last), .s_ready_o(b_ready),
    .m_data_o(b_mdata), .m_valid_o(b_mvalid), .m_last_o(b_mlast), .m_ready_i(b_mready),
    .m_sel_o(b_msel)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct packed { logic [DW-1:0] d; logic l; } beat_t;
  typedef struct packed { logic [DW-1:0] d; logic l; logic [SW-1:0] s; } obeat_t;

  beat_t   src_q [N][$];   // beats each source still has to send
  obeat_t  exp_q [$];      // beats that should be sitting in the output register
  int      sel_log [$];    // source port of every retired output beat

  // model state: packet-level view of the arbiter
  bit           m_idle = 1'b1;
  int           m_grant = 0;
  int           m_rr = N - 1;
  bit           mon_en = 1'b0;
  logic [N-1:0] acc_r = '0;

  // stimulus knobs
  int           vpct = 100;
  int           rpct = 100;
  logic [N-1:0] blk = '0;
  int           blk_cnt = 0;
  bit           force_lo = 1'b0;

  // Next winner: first requester found walking upward (wrapping) from the last-served port.
  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return 0;
  endfunction

  logic [N-1:0] mon_acc;
  logic [N-1:0] exp_rdy;
  logic [N-1:0] one_hot;
  bit           mon_can;
  obeat_t       ob;

  always @(negedge clk) begin
    if (mon_en) begin
      mon_acc = a_valid & a_ready;
      mon_can = (exp_q.size() == 0) || a_mready;
      // output register contents
      check("m_valid", a_mvalid, exp_q.size() != 0);
      if (a_mvalid && exp_q.size() != 0) begin
        check("m_data", a_mdata, exp_q[0].d);
        check("m_last", a_mlast, exp_q[0].l);
        check("m_sel",  a_msel,  exp_q[0].s);
      end
      if (a_mvalid && a_mready && exp_q.size() != 0) begin
        sel_log.push_back(int'(exp_q[0].s));
        void'(exp_q.pop_front());
      end
      // input side
      if (m_idle) begin
        check("s_ready_idle", a_ready, '0);
        if (|a_valid) begin
          m_grant = rr_pick(a_valid, m_rr);
          m_idle  = 1'b0;
        end
      end else begin
        one_hot = '0;
        one_hot[m_grant] = 1'b1;
        exp_rdy = mon_can ? one_hot : '0;
        check("s_ready", a_ready, exp_rdy);
        if (a_valid[m_grant] && mon_can) begin
          ob.d = a_data[m_grant*DW +: DW];
          ob.l = a_last[m_grant];
          ob.s = SW'(m_grant);
          exp_q.push_back(ob);
          if (a_last[m_grant]) begin
            m_idle = 1'b1;
            m_rr   = m_grant;
          end
        end
      end
      acc_r = mon_acc;
    end else begin
      acc_r = '0;
    end
  end

  task automatic add_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.d = DW'($urandom);
      b.l = (k == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      if (acc_r[p] && src_q[p].size() != 0) void'(src_q[p].pop_front());
      if (src_q[p].size() == 0 || blk[p]) a_valid[p] = 1'b0;
      else if (a_valid[p] && !acc_r[p])   a_valid[p] = 1'b1;
      else                                a_valid[p] = ($urandom_range(99) < vpct);
      if (src_q[p].size() != 0) begin
        a_data[p*DW +: DW] = src_q[p][0].d;
        a_last[p]          = src_q[p][0].l;
      end
    end
    acc_r    = '0;
    a_mready = force_lo ? 1'b0 : ($urandom_range(99) < rpct);
    if (blk_cnt > 0) blk_cnt--;
    else             blk = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_drain(input int maxc);
    bit empty;
    for (int i = 0; i < maxc; i++) begin
      empty = m_idle && exp_q.size() == 0 && !a_mvalid;
      for (int p = 0; p < N; p++) if (src_q[p].size() != 0) empty = 1'b0;
      if (empty) return;
      step();
    end
    check("drain_timeout", 1, 0);
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_rr   = N - 1;
    exp_q.delete();
    for (int p = 0; p < N; p++) src_q[p].delete();
    a_valid = '0;
    a_last  = '0;
    a_data  = '0;
    blk     = '0;
    blk_cnt = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_mvalid"}, a_mvalid, 0);
    check({tag, "_mdata"},  a_mdata,  0);
    check({tag, "_mlast"},  a_mlast,  0);
    check({tag, "_msel"},   a_msel,   0);
    check({tag, "_sready"}, a_ready,  0);
  endtask

  initial begin
    int base;
    int p0_sent, p2_sent, guard;
    logic [DW-1:0] hold_d;
    int fp_log [$];

    // 1: reset with random inputs -> all outputs zero
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      a_valid  = N'($urandom);
      a_last   = N'($urandom);
      a_data   = (N*DW)'($urandom);
      a_mready = 1'($urandom);
      b_valid  = N'($urandom);
      b_mready = 1'($urandom);
      #2;
      check_zero("reset");
      check("reset_b_mvalid", b_mvalid, 0);
      check("reset_b_sready", b_ready, 0);
    end
    model_reset();
    b_valid  = '0;
    b_mready = 1'b1;
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    mon_en = 1'b1;

    // 3: fixed priority -- ports 0 and 2 valid; port 2 served only after port 0 finishes
    p0_sent = 0;
    p2_sent = 0;
    guard   = 0;
    while (fp_log.size() < 8 && guard < 200) begin
      b_valid[0] = (p0_sent < 6);
      b_valid[2] = (p2_sent < 2);
      b_data[0*DW +: DW] = DW'(8'h10 + p0_sent);
      b_last[0]          = p0_sent[0];
      b_data[2*DW +: DW] = DW'(8'h20 + p2_sent);
      b_last[2]          = p2_sent[0];
      @(negedge clk);
      if (b_mvalid) fp_log.push_back(int'(b_msel));
      if (b_valid[0] && b_ready[0]) p0_sent++;
      if (b_valid[2] && b_ready[2]) p2_sent++;
      @(posedge clk);
      #1;
      guard++;
    end
    b_valid = '0;
    check("fp_count", fp_log.size(), 8);
    for (int k = 0; k < fp_log.size(); k++) check("fp_sel", fp_log[k], (k < 6) ? 0 : 2);

    // 2: round-robin, every port streams 2-beat packets -> 0,0,1,1,2,2,3,3,0,0,...
    vpct = 100;
    rpct = 100;
    sel_log.delete();
    for (int r = 0; r < 2; r++) for (int p = 0; p < N; p++) add_pkt(p, 2);
    step();
    wait_drain(500);
    check("rr_count", sel_log.size(), 16);
    for (int k = 0; k < sel_log.size() && k < 16; k++) check("rr_sel", sel_log[k], (k / 2) % N);

    // 4: backpressure for 5 cycles mid-packet
    sel_log.delete();
    add_pkt(2, 8);
    guard = 0;
    while (sel_log.size() < 2 && guard < 50) begin
      step();
      guard++;
    end
    force_lo = 1'b1;
    a_mready = 1'b0;
    hold_d   = a_mdata;
    repeat (5) step();
    check("bp_hold_data", a_mdata, hold_d);
    check("bp_hold_valid", a_mvalid, 1);
    check("bp_sready_low", a_ready, 0);
    force_lo = 1'b0;
    wait_drain(200);
    check("bp_count", sel_log.size(), 8);

    // 5: granted port 1 stalls 3 cycles while port 3 waits
    sel_log.delete();
    add_pkt(1, 4);
    guard = 0;
    while (src_q[1].size() == 4 && guard < 50) begin
      step();
      guard++;
    end
    blk[1]     = 1'b1;
    blk_cnt    = 2;
    a_valid[1] = 1'b0;
    add_pkt(3, 2);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_p3_ready", a_ready[3], 0);
    end
    wait_drain(200);
    check("stall_count", sel_log.size(), 6);
    for (int k = 0; k < sel_log.size() && k < 6; k++) check("stall_sel", sel_log[k], (k < 4) ? 1 : 3);

    // random traffic with random packet lengths (including single-beat packets)
    vpct = 50;
    rpct = 60;
    for (int r = 0; r < 6; r++) for (int p = 0; p < N; p++) add_pkt(p, $urandom_range(1, 4));
    wait_drain(5000);

    // 6: asynchronous reset mid-packet
    vpct = 100;
    rpct = 100;
    sel_log.delete();
    add_pkt(2, 6);
    add_pkt(3, 6);
    guard = 0;
    while (sel_log.size() < 2 && guard < 50) begin
      step();
      guard++;
    end
    #2;
    rst_n  = 1'b0;
    mon_en = 1'b0;
    #1;
    check_zero("areset");
    model_reset();
    repeat (2) step();
    rst_n  = 1'b1;
    mon_en = 1'b1;
    sel_log.delete();
    for (int p = 0; p < N; p++) add_pkt(p, 2);
    for (int p = 0; p < N; p++) a_valid[p] = 1'b1;
    for (int p = 0; p < N; p++) begin
      a_data[p*DW +: DW] = src_q[p][0].d;
      a_last[p]          = src_q[p][0].l;
    end
    wait_drain(500);
    base = (sel_log.size() > 0) ? sel_log[0] : -1;
    check("post_reset_first", base, 0);
    check("post_reset_count", sel_log.size(), 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

endmodule
